paralelo_serial_param: RTL and testbench
========================================

# paralelo_serial_param

Parametrised parallel-to-serial converter for the PHY transmit path, running entirely in the bit-clock domain. Accepts WIDTH-bit words over a valid/ready handshake into a one-entry holding buffer and serialises them at one bit per clock. It inserts IDLE_WORD whenever no data word is ready. After reset it emits a fixed preamble of idle words before accepting data, and flags word boundaries and data/idle status for the downstream line logic.

## Interface
- WIDTH, 8: word width in bits, at least 2.
- IDLE_WORD, 8'hBC: word transmitted when no data is pending (K28.5 comma).
- MSB_FIRST, 1: 1 = bit WIDTH-1 first; 0 = bit 0 first.
- INIT_IDLES, 4: idle words forced after reset before ready_out may assert, at least 1.
- clk_32f  input  1: bit clock. Single clock; all logic is on its rising edge.
- reset_L  input  1: asynchronous, active-low reset.
- data_in  input  WIDTH: parallel data word.
- valid_in  input  1: data_in is valid.
- ready_out  output  1: the block can accept a word this cycle.
- data_out  output  1: serial bit, registered.
- word_start  output  1: registered, high while data_out carries the first bit of a word.
- is_data  output  1: registered, high while data_out carries a bit of a data word (not idle).

## Operation
- Internal state:
  - cur: word being serialised.
  - cnt: bit index, $clog2(WIDTH) bits, counts 0..WIDTH-1 and wraps.
  - cur_is_data: data/idle flag for cur.
  - hold register with hold_full flag.
  - idle_cnt: preamble counter.
  - state: INIT or ACTIVE.
- Every edge:
  - data_out <= bit of cur selected by cnt (index WIDTH-1-cnt if MSB_FIRST, else cnt).
  - word_start <= (cnt==0).
  - is_data <= cur_is_data.
  - cnt <= cnt+1, wrapping from WIDTH-1 to 0.
- Load edge (cnt==WIDTH-1):
  - If hold_full: cur <= hold, cur_is_data <= 1, and hold_full clears unless refilled on the same edge.
  - Otherwise: cur <= IDLE_WORD, cur_is_data <= 0.
- Handshake:
  - ready_out = (state==ACTIVE) && (!hold_full || cnt==WIDTH-1). It is combinational and does not depend on valid_in.
  - A transfer occurs on an edge where valid_in && ready_out; data_in is written to hold and hold_full is set.
  - Simultaneous drain and accept on a load edge: hold moves to cur and the new word enters hold on the same edge. No data is lost and no bubble is inserted.
  - When hold_full and not a load edge, ready_out is low and data_in/valid_in are ignored.
- State machine:
  - INIT: idle_cnt increments on each load edge.
  - INIT -> ACTIVE on the load edge where idle_cnt==INIT_IDLES-1. ready_out can first be high on the cycle after that edge.
  - ACTIVE is held until reset. There are no other transitions.
- Reset (asynchronous assertion, any time including mid-word):
  - data_out=0, word_start=0, is_data=0, ready_out=0.
  - cnt=0, cur=IDLE_WORD, cur_is_data=0, hold_full=0, idle_cnt=0, state=INIT.
  - A partially sent word and any held word are discarded.

## Timing
- Word period is exactly WIDTH clocks. Words are back-to-back with no gap bits.
- First edge after reset release: data_out = first bit of IDLE_WORD, word_start=1.
- Word accepted into hold with an empty hold at edge E: it loads at the next load edge L (L may equal E when E itself is a load edge). Its first bit is on data_out after edge L+1.
- Worst-case latency from accept to first bit is WIDTH+1 clocks.
- Sustained throughput is one word per WIDTH clocks when valid_in is held high.
- Preamble is INIT_IDLES*WIDTH bits. In ACTIVE, any word slot with no held data is IDLE_WORD.

## Structure
- Shared package phy_tx_pkg holds:
  - the K28.5 constant 8'hBC;
  - the INIT/ACTIVE state encoding;
  - the default WIDTH and INIT_IDLES values.
- One sub-module, ps_hold_buf: a one-entry holding register with full flag, parametrised by WIDTH. It takes push and pop inputs and supports push and pop on the same cycle.
- The counter, state machine and bit select stay in the top module.

## Test plan
- Reset release, valid_in=0, WIDTH=8: first 32 bits are 4×10111100, word_start high every 8th bit, is_data=0. ready_out first goes high after bit 32.
- Single word 8'hA5 accepted in ACTIVE: data_out 10100101 follows in the next word slot with is_data=1. Then 10111100 resumes with is_data=0.
- valid_in held high with words 8'h01, 8'h02, 8'h03: accepts land on load edges, the words serialise contiguously, and ready_out never deasserts on load edges.
- hold full mid-word with valid_in high: ready_out=0 and data_in changes are ignored. The next accepted word is taken on the load edge, so nothing is dropped or duplicated.
- reset_L pulsed low at bit 3 of a data word: outputs go to 0 immediately, and the stream restarts with the 4-word idle preamble.
- MSB_FIRST=0, WIDTH=10, IDLE_WORD=10'h17C, word 10'h2AB: data_out emits 1101010101 (bit 0 first).

Source files
------------

// File: rtl/phy_tx_pkg.sv
// Shared constants and state encoding for the PHY transmit path.
package phy_tx_pkg;

   localparam logic [7:0] K28_5          = 8'hBC;
   localparam int         DEF_WIDTH      = 8;
   localparam int         DEF_INIT_IDLES = 4;

   typedef enum logic {
      ST_INIT   = 1'b0,
      ST_ACTIVE = 1'b1
   } tx_state_t;

endpackage

// File: rtl/ps_hold_buf.sv
// One-entry holding register with full flag; push and pop may coincide.
module ps_hold_buf
   import phy_tx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk_32f,
   input  logic             reset_L,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full
);

   // NOTE: the data register is reset as well so no X ever reaches the serialiser.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         dout <= '0;
         full <= 1'b0;
      end else if (push) begin
         dout <= din;
         full <= 1'b1;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial converter: one bit per clock, idle fill, reset preamble.
module paralelo_serial_param
   import phy_tx_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter logic [WIDTH-1:0] IDLE_WORD  = K28_5,
   parameter bit               MSB_FIRST  = 1'b1,
   parameter int               INIT_IDLES = DEF_INIT_IDLES
) (
   input  logic             clk_32f,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             data_out,
   output logic             word_start,
   output logic             is_data
);

   localparam int CW = $clog2(WIDTH);
   localparam int IW = $clog2(INIT_IDLES + 1);

   tx_state_t        state;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    sel;
   logic [WIDTH-1:0] cur;
   logic             cur_is_data;
   logic [IW-1:0]    idle_cnt;
   logic [WIDTH-1:0] hold_data;
   logic             hold_full;
   logic             load;
   logic             push;
   logic             pop;

   assign load = (cnt == CW'(WIDTH - 1));

   // The hold slot frees on a load edge, so a new word can be taken there too.
   assign ready_out = (state == ST_ACTIVE) && (!hold_full || load);
   assign push      = valid_in && ready_out;
   assign pop       = load && hold_full;

   always_comb begin
      sel = cnt;
      if (MSB_FIRST) sel = CW'(WIDTH - 1) - cnt;
   end

   ps_hold_buf #(.WIDTH(WIDTH)) u_hold (
      .clk_32f (clk_32f),
      .reset_L (reset_L),
      .push    (push),
      .pop     (pop),
      .din     (data_in),
      .dout    (hold_data),
      .full    (hold_full)
   );

   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         state       <= ST_INIT;
         cnt         <= '0;
         cur         <= IDLE_WORD;
         cur_is_data <= 1'b0;
         idle_cnt    <= '0;
         data_out    <= 1'b0;
         word_start  <= 1'b0;
         is_data     <= 1'b0;
      end else begin
         data_out   <= cur[sel];
         word_start <= (cnt == '0);
         is_data    <= cur_is_data;
         cnt        <= load ? '0 : cnt + 1'b1;
         if (load) begin
            cur         <= hold_full ? hold_data : IDLE_WORD;
            cur_is_data <= hold_full;
            if (state == ST_INIT) begin
               idle_cnt <= idle_cnt + 1'b1;
               if (idle_cnt == IW'(INIT_IDLES - 1)) state <= ST_ACTIVE;
            end
         end
      end
   end

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Randomized bench: two configurations checked against a bit-stream queue model.
module tb_paralelo_serial_param;

   typedef struct {
      logic b;
      logic ws;
      logic dat;
   } bit_t;

   logic       clk_32f = 1'b0;
   logic       reset_L;
   logic [1:0] valid_in, ready_out, data_out, word_start, is_data;
   logic [7:0] data_a;
   logic [9:0] data_b;

   always #5 clk_32f = ~clk_32f;

   paralelo_serial_param #(.WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b1), .INIT_IDLES(4)) dut_a (
      .clk_32f    (clk_32f),
      .reset_L    (reset_L),
      .data_in    (data_a),
      .valid_in   (valid_in[0]),
      .ready_out  (ready_out[0]),
      .data_out   (data_out[0]),
      .word_start (word_start[0]),
      .is_data    (is_data[0])
   );

   paralelo_serial_param #(.WIDTH(10), .IDLE_WORD(10'h17C), .MSB_FIRST(1'b0), .INIT_IDLES(4)) dut_b (
      .clk_32f    (clk_32f),
      .reset_L    (reset_L),
      .data_in    (data_b),
      .valid_in   (valid_in[1]),
      .ready_out  (ready_out[1]),
      .data_out   (data_out[1]),
      .word_start (word_start[1]),
      .is_data    (is_data[1])
   );

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: expected output bit stream plus a pending-word flag.
   int          wd[2]    = '{8, 10};
   bit          msb[2]   = '{1'b1, 1'b0};
   logic [15:0] idlew[2] = '{16'h00BC, 16'h017C};
   bit_t        eq[2][$];
   int          c[2];
   bit          pend[2];
   logic [15:0] pw[2];
   int          lpos[2];
   bit          ldat[2];
   bit          v[2];
   logic [15:0] drv[2];
   bit          acc[2];

   function automatic void push_word(input int d, input logic [15:0] w, input bit dat);
      for (int i = 0; i < wd[d]; i++) begin
         bit_t e;
         e.b   = msb[d] ? w[wd[d]-1-i] : w[i];
         e.ws  = (i == 0);
         e.dat = dat;
         eq[d].push_back(e);
      end
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         c[d]    = 0;
         pend[d] = 1'b0;
         lpos[d] = 0;
         ldat[d] = 1'b0;
         eq[d].delete();
         push_word(d, idlew[d], 1'b0);
      end
   endfunction

   function automatic bit model_ready(input int d);
      return (c[d] >= 4 * wd[d]) && (!pend[d] || (c[d] % wd[d]) == wd[d] - 1);
   endfunction

   task automatic apply_inputs();
      valid_in[0] = v[0];
      valid_in[1] = v[1];
      data_a      = drv[0][7:0];
      data_b      = drv[1][9:0];
   endtask

   // Entered and left at a falling edge.
   task automatic cycle();
      for (int d = 0; d < 2; d++) begin
         bit r;
         r = model_ready(d);
         check(d ? "B.ready_out" : "A.ready_out", {31'd0, ready_out[d]}, {31'd0, r});
         acc[d] = v[d] && r;
      end
      apply_inputs();
      @(posedge clk_32f);
      #1;
      for (int d = 0; d < 2; d++) begin
         bit_t e;
         bit   ld;
         ld = (c[d] % wd[d]) == wd[d] - 1;
         e  = eq[d].pop_front();
         if (ld) begin
            push_word(d, pend[d] ? pw[d] : idlew[d], pend[d]);
            pend[d] = 1'b0;
         end
         if (acc[d]) begin
            pend[d] = 1'b1;
            pw[d]   = drv[d];
         end
         c[d]++;
         lpos[d] = e.ws ? 0 : lpos[d] + 1;
         ldat[d] = e.dat;
         check(d ? "B.data_out"   : "A.data_out",   {31'd0, data_out[d]},   {31'd0, e.b});
         check(d ? "B.word_start" : "A.word_start", {31'd0, word_start[d]}, {31'd0, e.ws});
         check(d ? "B.is_data"    : "A.is_data",    {31'd0, is_data[d]},    {31'd0, e.dat});
      end
      @(negedge clk_32f);
   endtask

   task automatic offer(input int d, input logic [15:0] w);
      bit done;
      done   = 1'b0;
      v[d]   = 1'b1;
      drv[d] = w;
      for (int k = 0; k < 60 && !done; k++) begin
         cycle();
         done = acc[d];
      end
      if (!done) check(d ? "B.offer_timeout" : "A.offer_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_reset_outputs();
      for (int d = 0; d < 2; d++) begin
         check(d ? "B.rst_ready"  : "A.rst_ready",  {31'd0, ready_out[d]},  32'd0);
         check(d ? "B.rst_dout"   : "A.rst_dout",   {31'd0, data_out[d]},   32'd0);
         check(d ? "B.rst_wstart" : "A.rst_wstart", {31'd0, word_start[d]}, 32'd0);
         check(d ? "B.rst_isdata" : "A.rst_isdata", {31'd0, is_data[d]},    32'd0);
      end
   endtask

   task automatic random_run(input int n);
      for (int k = 0; k < n; k++) begin
         for (int d = 0; d < 2; d++) begin
            v[d]   = ($urandom_range(0, 3) != 0);
            drv[d] = 16'($urandom);
         end
         cycle();
      end
      v = '{1'b0, 1'b0};
   endtask

   initial begin
      bit hit;
      reset_L = 1'b0;
      v       = '{1'b0, 1'b0};
      drv     = '{16'd0, 16'd0};
      apply_inputs();
      #12;
      check_reset_outputs();
      @(negedge clk_32f);
      reset_L = 1'b1;
      model_reset();

      repeat (45) cycle();

      offer(0, 16'h00A5);
      v[0] = 1'b0;
      repeat (20) cycle();
      offer(1, 16'h02AB);
      v[1] = 1'b0;
      repeat (25) cycle();

      for (int i = 1; i <= 3; i++) offer(0, 16'(i));
      v[0] = 1'b0;
      repeat (30) cycle();

      random_run(600);

      // Reset while the first DUT is emitting bit 3 of a data word.
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         v[0]   = 1'b1;
         drv[0] = 16'($urandom);
         cycle();
         hit = ldat[0] && (lpos[0] == 3);
      end
      v[0] = 1'b0;
      if (!hit) check("reset_target_timeout", 32'd0, 32'd1);
      reset_L = 1'b0;
      #1;
      check_reset_outputs();
      @(posedge clk_32f);
      @(negedge clk_32f);
      reset_L = 1'b1;
      model_reset();
      apply_inputs();

      repeat (45) cycle();
      random_run(300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
